led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of multiplexed anode rows (1..8).
REQ-002 Parameter COLS, default 8, number of cathode columns per row (1..16).
REQ-003 Parameter DIV_BITS, default 8, tick prescaler width; one tick every 2^DIV_BITS clk cycles.
REQ-004 Parameter DWELL, default 16, ticks each row stays displayed (>=1).
REQ-005 Parameter HOLD_FRAMES, default 8, full frames an LED stays lit after an activity pulse (1..255).
REQ-006 Parameter COL_ACTIVE_LOW, default 1, column level that lights an LED (1: drive 0).
REQ-007 clk  input  1  single system clock; every flop is on posedge clk.
REQ-008 rst_n  input  1  reset, synchronous and active-low.
REQ-009 act  input  ROWS*COLS  activity strobes; LED index = row*COLS+col; any width of pulse is accepted.
REQ-010 sck  output  1  shift-register serial clock (74HC595 SRCLK).
REQ-011 rck  output  1  shift-register latch clock (74HC595 RCLK).
REQ-012 ser  output  1  serial data.
REQ-013 oe_n  output  1  shift-register output enable, active-low (blanking).
REQ-014 frame_tick  output  1  one-clk pulse when the last row's dwell ends.

Function
REQ-015 Prescaler: free-running DIV_BITS counter; tick = counter all-ones; the FSM SHALL advance only on tick and SHALL NOT use a derived clock.
REQ-016 Stretch: per-LED counter (8 bits); act[i] high in any clk loads HOLD_FRAMES; on frame_tick a non-zero counter decrements by 1; LED lit = counter != 0.
REQ-017 Act and frame_tick in the same clk: load SHALL win (counter = HOLD_FRAMES).
REQ-018 Shift word SR_BITS = ROWS+COLS; shifted MSB first: row one-hot bits row ROWS-1..0 (1 = active row), then column bits COLS-1..0 (polarity per COL_ACTIVE_LOW).
REQ-019 FSM states: IDLE, LOAD, DATA, CLK, LATCH, DWELL; transitions on tick only.
REQ-020 IDLE: entered from reset; -> LOAD on next tick.
REQ-021 LOAD: oe_n=1; snapshot current row's lit bits into shift word; bitcnt=SR_BITS-1; -> DATA.
REQ-022 DATA: sck=0, ser=word MSB; -> CLK.
REQ-023 CLK: sck=1; shift word left; bitcnt=0 -> LATCH, else bitcnt-1 -> DATA.
REQ-024 LATCH: sck=0, rck=1; -> DWELL.
REQ-025 DWELL: rck=0, oe_n=0 for DWELL ticks; then oe_n=1, row wraps ROWS-1 -> 0 (frame_tick pulse on wrap), -> LOAD.
REQ-026 oe_n SHALL be 1 whenever sck or rck toggles; exactly SR_BITS sck rising edges between consecutive rck rising edges.
REQ-027 Act latency: LED appears at the next LOAD of its row; row changes mid-shift do not alter the word being shifted.

Reset
REQ-028 rst_n low at a clk edge: sck=0, rck=0, ser=0, oe_n=1, frame_tick=0, row=0, bitcnt=0, prescaler=0, all stretch counters=0, state=IDLE.
REQ-029 Reset mid-shift SHALL abort the word; after release the first latch carries a complete SR_BITS word for row 0.

Structure
REQ-030 Shared package led_pkg holds FSM state encoding and SR_BITS/row-index width functions.
REQ-031 Sub-module act_stretch: array of ROWS*COLS hold counters, inputs act and frame_tick, output lit vector.

Verification (ROWS=4, COLS=8, DIV_BITS=2, DWELL=2, HOLD_FRAMES=3, COL_ACTIVE_LOW=1)
REQ-032 Reset, act=0 -> first four latched 12-bit words 0001_11111111, 0010_11111111, 0100_11111111, 1000_11111111 (row bits first).
REQ-033 act[0] one-clk pulse -> row-0 word col bit0 = 0 for exactly 3 frames, 1 in frame 4.
REQ-034 act[31] held high -> row-3 word col bit7 = 0 every frame.
REQ-035 act[5] pulsed in same clk as frame_tick after prior load -> stretch counter reads 3, lit 3 more frames.
REQ-036 rst_n low for 1 clk during CLK of bit 5 -> next clk sck=0, oe_n=1; next rck preceded by 12 sck edges, row 0 word.
REQ-037 Monitor entire run: sck edges per rck = 12; oe_n=1 at every sck/rck edge; frame_tick period = 4 rows x (1+24+1+2) ticks x 4 clk.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix scanner: FSM state encoding and
// shift-word / row-index sizing helpers.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DATA,
        ST_CLK,
        ST_LATCH,
        ST_DWELL
    } scan_state_t;

    function automatic int sr_bits(input int rows, input int cols);
        return rows + cols;
    endfunction

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/act_stretch.sv
// Per-LED activity stretcher: a strobe reloads the hold count, each frame
// tick counts it down, and the LED is lit while the count is non-zero.
module act_stretch
    import led_pkg::*;
#(
    parameter int N           = 32,
    parameter int HOLD_FRAMES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] act,
    input  logic         frame_tick,
    output logic [N-1:0] lit
);

    localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

    logic [7:0] hold_cnt [N];

    // A fresh strobe beats a simultaneous frame-tick decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                hold_cnt[i] <= 8'd0;
            end else if (act[i]) begin
                hold_cnt[i] <= HOLD;
            end else if (frame_tick && (hold_cnt[i] != 8'd0)) begin
                hold_cnt[i] <= hold_cnt[i] - 8'd1;
            end
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < N; i++) begin
            lit[i] = (hold_cnt[i] != 8'd0);
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix scanner driving a 74HC595 chain with stretched
// activity indication; every FSM step happens on a prescaler tick.
//
// state | meaning
// IDLE  | after reset, wait for the first tick
// LOAD  | blank, snapshot current row into the shift word
// DATA  | sck low, present word MSB on ser
// CLK   | sck high, shift word, count bits
// LATCH | sck low, rck high
// DWELL | rck low, row displayed for DWELL ticks, then next row
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 8,
    parameter int DIV_BITS       = 8,
    parameter int DWELL          = 16,
    parameter int HOLD_FRAMES    = 8,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] act,
    output logic                 sck,
    output logic                 rck,
    output logic                 ser,
    output logic                 oe_n,
    output logic                 frame_tick
);

    localparam int SR_BITS = sr_bits(ROWS, COLS);
    localparam int RW      = row_width(ROWS);
    localparam int BW      = $clog2(SR_BITS);
    localparam int DWW     = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
    localparam logic [BW-1:0]  BIT_FIRST  = BW'(SR_BITS - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

    scan_state_t          state;
    logic [DIV_BITS-1:0]  presc;
    logic                 tick;
    logic [RW-1:0]        row;
    logic [BW-1:0]        bitcnt;
    logic [DWW-1:0]       dwell_cnt;
    logic [SR_BITS-1:0]   word;
    logic [ROWS*COLS-1:0] lit;
    logic [COLS-1:0]      row_lit;
    logic [ROWS-1:0]      row_hot;
    logic [COLS-1:0]      col_bits;

    act_stretch #(
        .N           (ROWS*COLS),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_stretch (
        .clk        (clk),
        .rst_n      (rst_n),
        .act        (act),
        .frame_tick (frame_tick),
        .lit        (lit)
    );

    assign tick = &presc;

    always_comb begin
        row_lit  = lit[int'(row)*COLS +: COLS];
        row_hot  = ROWS'(1) << row;
        col_bits = (COL_ACTIVE_LOW != 0) ? ~row_lit : row_lit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            sck        <= 1'b0;
            rck        <= 1'b0;
            ser        <= 1'b0;
            oe_n       <= 1'b1;
            frame_tick <= 1'b0;
            row        <= '0;
            bitcnt     <= '0;
            dwell_cnt  <= '0;
            word       <= '0;
        end else begin
            presc      <= presc + 1'b1;
            frame_tick <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: state <= ST_LOAD;
                    ST_LOAD: begin
                        oe_n   <= 1'b1;
                        word   <= {row_hot, col_bits};
                        bitcnt <= BIT_FIRST;
                        state  <= ST_DATA;
                    end
                    ST_DATA: begin
                        sck   <= 1'b0;
                        ser   <= word[SR_BITS-1];
                        state <= ST_CLK;
                    end
                    ST_CLK: begin
                        sck  <= 1'b1;
                        word <= {word[SR_BITS-2:0], 1'b0};
                        if (bitcnt == '0) begin
                            state <= ST_LATCH;
                        end else begin
                            bitcnt <= bitcnt - 1'b1;
                            state  <= ST_DATA;
                        end
                    end
                    ST_LATCH: begin
                        sck       <= 1'b0;
                        rck       <= 1'b1;
                        dwell_cnt <= DWELL_LAST;
                        state     <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        // oe_n stays low through the exit tick; LOAD re-blanks.
                        rck  <= 1'b0;
                        oe_n <= 1'b0;
                        if (dwell_cnt == '0) begin
                            state <= ST_LOAD;
                            if (row == ROW_LAST) begin
                                row        <= '0;
                                frame_tick <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scanner bench: decodes the serial stream and compares every latched word,
// frame tick and blanking condition against a frame/row timing model.
module tb_led_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int NLED = ROWS * COLS;
    localparam int SRB  = ROWS + COLS;
    localparam int HOLD = 3;
    localparam int CLK_PER_TICK = 4;
    localparam int TICKS_PER_ROW = 1 + 2 * SRB + 1 + 2;
    localparam int FRAME_CLK = ROWS * TICKS_PER_ROW * CLK_PER_TICK;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NLED-1:0] act = '0;
    logic            sck, rck, ser, oe_n, frame_tick;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV_BITS(2), .DWELL(2),
        .HOLD_FRAMES(HOLD), .COL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .act(act), .sck(sck), .rck(rck),
        .ser(ser), .oe_n(oe_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          k;
    int          hold [NLED];
    logic        ft_exp;
    logic [31:0] exp_word;
    logic [31:0] cap;
    int          nsck;
    int          lat_seen, lat_exp;
    logic        sck_q, rck_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance the model for the edge, then observe 1 time unit later.
    task automatic step();
        int t, u, pos, r;
        logic ft_new;
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < NLED; i++) hold[i] = 0;
            ft_exp = 1'b0;
            cap = '0;
            nsck = 0;
        end else begin
            k++;
            ft_new = 1'b0;
            if ((k % CLK_PER_TICK) == 0 && k >= 2 * CLK_PER_TICK) begin
                t   = k / CLK_PER_TICK;
                u   = t - 2;
                pos = u % TICKS_PER_ROW;
                r   = (u / TICKS_PER_ROW) % ROWS;
                if (pos == 0) begin
                    exp_word = 32'(1 << r) << COLS;
                    for (int c = 0; c < COLS; c++)
                        if (hold[r*COLS + c] == 0) exp_word[c] = 1'b1;
                end
                if (pos == 2 * SRB + 1) lat_exp++;
                if (pos == TICKS_PER_ROW - 1 && r == ROWS - 1) ft_new = 1'b1;
            end
            for (int i = 0; i < NLED; i++) begin
                if (act[i]) hold[i] = HOLD;
                else if (ft_exp && hold[i] > 0) hold[i] = hold[i] - 1;
            end
            ft_exp = ft_new;
        end
        #1;
        chk("frame_tick", 32'(frame_tick), 32'(ft_exp));
        if (sck !== sck_q) begin
            chk("oe_n_at_sck_edge", 32'(oe_n), 32'd1);
            if (sck === 1'b1) begin
                cap = {cap[30:0], ser};
                nsck++;
            end
        end
        if (rck === 1'b1 && rck_q === 1'b0) begin
            chk("oe_n_at_rck_rise", 32'(oe_n), 32'd1);
            chk("sck_per_rck", 32'(nsck), 32'(SRB));
            chk("latched_word", cap & 32'hFFF, exp_word);
            nsck = 0;
            lat_seen++;
        end
        sck_q = sck;
        rck_q = rck;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ft(input string tag);
        logic found = 1'b0;
        for (int n = 0; n < 2 * FRAME_CLK; n++) begin
            if (frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic run_random(input int n, input logic [NLED-1:0] base);
        int   left = 0;
        int   idx  = 0;
        for (int i = 0; i < n; i++) begin
            act = base;
            if (left > 0) begin
                act[idx] = 1'b1;
                left--;
            end else if ($urandom_range(0, 99) < 3) begin
                idx  = $urandom_range(0, NLED - 1);
                left = $urandom_range(0, 7);
                act[idx] = 1'b1;
            end
            step();
        end
        act = base;
    endtask

    initial begin
        logic found;
        k = 0; ft_exp = 1'b0; exp_word = '0; cap = '0; nsck = 0;
        lat_seen = 0; lat_exp = 0; sck_q = 1'b0; rck_q = 1'b0;
        for (int i = 0; i < NLED; i++) hold[i] = 0;

        rst_n = 1'b0;
        run(3);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_rck", 32'(rck), 32'd0);
        chk("rst_ser", 32'(ser), 32'd0);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;

        // Idle matrix: every latched word is a one-hot row with all columns dark.
        run(2 * FRAME_CLK);

        // Single-clock strobe on LED 0 just after a frame boundary.
        wait_ft("wait_ft_led0");
        step();
        act[0] = 1'b1;
        step();
        act[0] = 1'b0;
        run(5 * FRAME_CLK);

        // LED 31 held high while other LEDs see random strobes.
        run_random(3 * FRAME_CLK, NLED'(1) << 31);

        // LED 5 strobed, then re-strobed in the very clock frame_tick is high.
        act[5] = 1'b1;
        step();
        act[5] = 1'b0;
        wait_ft("wait_ft_led5a");
        step();
        wait_ft("wait_ft_led5b");
        act[5] = 1'b1;
        step();
        act[5] = 1'b0;
        run(5 * FRAME_CLK);

        // Reset pulse in the middle of a word.
        found = 1'b0;
        for (int n = 0; n < FRAME_CLK; n++) begin
            if (nsck == 5 && sck === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_mid_shift", 32'(found), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_sck", 32'(sck), 32'd0);
        chk("midrst_oe_n", 32'(oe_n), 32'd1);
        chk("midrst_rck", 32'(rck), 32'd0);
        run(2 * FRAME_CLK);

        run_random(4 * FRAME_CLK, '0);
        run(4 * FRAME_CLK);

        chk("latch_count", 32'(lat_seen), 32'(lat_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
